// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state encodings (used by rxuart and txuart)
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BAUD = 16;
  localparam int DATA_BITS             = 8;
  localparam int FRAME_BITS            = 10;

  localparam logic [2:0] RX_IDLE   = 3'd0;
  localparam logic [2:0] RX_START  = 3'd1;
  localparam logic [2:0] RX_DATA   = 3'd2;
  localparam logic [2:0] RX_PARITY = 3'd3;
  localparam logic [2:0] RX_STOP   = 3'd4;
  localparam logic [2:0] RX_BREAK  = 3'd5;

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - two-flop synchroniser with a configurable reset value
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RESET_VAL;
      o_q    <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      o_q    <= r_meta;
    end
  end

endmodule

// File: rtl/rxuart.sv
// rtl/rxuart.sv - UART receiver, 8N1 with mid-bit sampling and a one-cycle byte strobe.
// Defining RXUART_PARITY_EN adds one even-parity bit between the data and stop bits.
module rxuart
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BAUD = DEFAULT_CLKS_PER_BAUD
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_uart_rx,
  output logic       o_rx_stb,
  output logic [7:0] o_rx_data,
  output logic       o_frame_err,
  output logic       o_parity_err,
  output logic       o_rx_busy
);

  localparam int              CW     = $clog2(CLKS_PER_BAUD);
  localparam logic [CW-1:0]   RELOAD = CW'(CLKS_PER_BAUD - 1);
  localparam logic [CW-1:0]   HALF   = CW'(CLKS_PER_BAUD / 2 - 1);

  logic                 w_rx_s;
  logic                 w_tick;
  logic [2:0]           r_state;
  logic [CW-1:0]        r_baud_cnt;
  logic [2:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
`ifdef RXUART_PARITY_EN
  logic                 r_parity;
`endif

  uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_uart_rx),
    .o_q     (w_rx_s)
  );

  assign w_tick    = (r_baud_cnt == '0);
  assign o_rx_busy = (r_state != RX_IDLE);

`ifndef RXUART_PARITY_EN
  assign o_parity_err = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= RX_IDLE;
      r_baud_cnt  <= HALF;
      r_bit_idx   <= 3'd0;
      r_shift     <= '0;
      o_rx_stb    <= 1'b0;
      o_rx_data   <= 8'h00;
      o_frame_err <= 1'b0;
`ifdef RXUART_PARITY_EN
      r_parity     <= 1'b0;
      o_parity_err <= 1'b0;
`endif
    end else begin
      o_rx_stb    <= 1'b0;
      o_frame_err <= 1'b0;
`ifdef RXUART_PARITY_EN
      o_parity_err <= 1'b0;
`endif
      // Preloading half a bit while idle puts every later tick at mid-bit.
      if (r_state == RX_IDLE)
        r_baud_cnt <= HALF;
      else if (w_tick)
        r_baud_cnt <= RELOAD;
      else
        r_baud_cnt <= r_baud_cnt - 1'b1;

      case (r_state)
        RX_IDLE: begin
          if (!w_rx_s)
            r_state <= RX_START;
        end
        RX_START: begin
          if (w_tick) begin
            if (!w_rx_s) begin
              r_state   <= RX_DATA;
              r_bit_idx <= 3'd0;
            end else begin
              r_state <= RX_IDLE;
            end
          end
        end
        RX_DATA: begin
          if (w_tick) begin
            r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef RXUART_PARITY_EN
              r_state <= RX_PARITY;
`else
              r_state <= RX_STOP;
`endif
            end
          end
        end
`ifdef RXUART_PARITY_EN
        RX_PARITY: begin
          if (w_tick) begin
            r_parity <= w_rx_s;
            r_state  <= RX_STOP;
          end
        end
`endif
        RX_STOP: begin
          if (w_tick) begin
            o_rx_data <= r_shift;
            o_rx_stb  <= 1'b1;
`ifdef RXUART_PARITY_EN
            o_parity_err <= (^r_shift) != r_parity;
`endif
            if (w_rx_s) begin
              r_state <= RX_IDLE;
            end else begin
              o_frame_err <= 1'b1;
              r_state     <= RX_BREAK;
            end
          end
        end
        RX_BREAK: begin
          if (w_rx_s)
            r_state <= RX_IDLE;
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rxuart.sv
// tb/tb_rxuart.sv - directed self-checking bench for rxuart (optionally built with RXUART_PARITY_EN)
module tb_rxuart;

  localparam int CPB = 16;
`ifdef RXUART_PARITY_EN
  localparam int LAT = 2 + 8 + 10 * CPB + 1;
`else
  localparam int LAT = 2 + 8 + 9 * CPB + 1;
`endif

  logic       clk;
  logic       rst_n;
  logic       uart_rx;
  logic       rx_stb;
  logic [7:0] rx_data;
  logic       frame_err;
  logic       parity_err;
  logic       rx_busy;

  int total = 0;
  int bad   = 0;

  int         cyc = 0;
  int         stb_count = 0;
  int         stb_cyc = 0;
  int         stray = 0;
  logic [7:0] last_data = 8'h00;
  logic [7:0] prev_data = 8'h00;
  logic       last_fe = 1'b0;
  logic       last_pe = 1'b0;

  rxuart #(.CLKS_PER_BAUD(CPB)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_uart_rx    (uart_rx),
    .o_rx_stb     (rx_stb),
    .o_rx_data    (rx_data),
    .o_frame_err  (frame_err),
    .o_parity_err (parity_err),
    .o_rx_busy    (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rx_stb) begin
      stb_count++;
      stb_cyc   = cyc;
      prev_data = last_data;
      last_data = rx_data;
      last_fe   = frame_err;
      last_pe   = parity_err;
    end else if (frame_err || parity_err) begin
      stray++;
    end
  end

  task automatic drive_bit(input logic v);
    uart_rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_flip);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef RXUART_PARITY_EN
    drive_bit((^d) ^ par_flip);
`else
    if (par_flip) drive_bit(1'b1);
`endif
    drive_bit(stop_v);
  endtask

  task automatic idle_bits(input int n);
    uart_rx = 1'b1;
    repeat (n * CPB) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    uart_rx = 1'b1;
    repeat (20 * CPB) @(posedge clk);
    #1;
    total++;
    if ({rx_stb, rx_data, frame_err, parity_err, rx_busy} !== 12'h000) begin
      bad++;
      $display("FAIL reset_hold got=%h want=000", {rx_stb, rx_data, frame_err, parity_err, rx_busy});
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({rx_stb, rx_data, frame_err, parity_err, rx_busy} !== 12'h000) begin
      bad++;
      $display("FAIL reset_release got=%h want=000", {rx_stb, rx_data, frame_err, parity_err, rx_busy});
    end
    @(posedge clk); #1;
    idle_bits(20);
    total++;
    if (stb_count !== 0) begin
      bad++;
      $display("FAIL reset_no_stb got=%0d want=0", stb_count);
    end
  endtask

  task automatic test_single_frame();
    int c0, s0;
    c0 = stb_count;
    s0 = cyc;
    send_frame(8'hA5, 1'b1, 1'b0);
    idle_bits(2);
    total++;
    if (stb_count - c0 !== 1) begin
      bad++;
      $display("FAIL a5_count got=%0d want=1", stb_count - c0);
    end
    total++;
    if (stb_cyc - s0 !== LAT) begin
      bad++;
      $display("FAIL a5_latency got=%0d want=%0d", stb_cyc - s0, LAT);
    end
    total++;
    if (last_data !== 8'hA5 || rx_data !== 8'hA5) begin
      bad++;
      $display("FAIL a5_data got=%h/%h want=a5", last_data, rx_data);
    end
    total++;
    if (last_fe !== 1'b0 || last_pe !== 1'b0) begin
      bad++;
      $display("FAIL a5_errs got=fe%b pe%b want=fe0 pe0", last_fe, last_pe);
    end
    total++;
    if (rx_busy !== 1'b0) begin
      bad++;
      $display("FAIL a5_idle got=%b want=0", rx_busy);
    end
  endtask

  task automatic test_glitch();
    int   c0;
    logic seen;
    c0   = stb_count;
    seen = 1'b0;
    uart_rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    uart_rx = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rx_busy) seen = 1'b1;
    end
    idle_bits(3);
    total++;
    if (seen !== 1'b1) begin
      bad++;
      $display("FAIL glitch_busy got=%b want=1", seen);
    end
    total++;
    if (stb_count - c0 !== 0 || rx_busy !== 1'b0) begin
      bad++;
      $display("FAIL glitch_nostb got=%0d busy=%b want=0 busy=0", stb_count - c0, rx_busy);
    end
    total++;
    if (rx_data !== 8'hA5) begin
      bad++;
      $display("FAIL glitch_data got=%h want=a5", rx_data);
    end
  endtask

  task automatic test_break();
    int c0;
    c0 = stb_count;
    send_frame(8'h3C, 1'b0, 1'b0);
    uart_rx = 1'b0;
    repeat (3 * 10 * CPB) @(posedge clk);
    #1;
    total++;
    if (stb_count - c0 !== 1 || last_data !== 8'h3C || last_fe !== 1'b1) begin
      bad++;
      $display("FAIL break_frame got=n%0d d%h fe%b want=n1 d3c fe1", stb_count - c0, last_data, last_fe);
    end
    total++;
    if (rx_busy !== 1'b1) begin
      bad++;
      $display("FAIL break_busy got=%b want=1", rx_busy);
    end
    idle_bits(2);
    total++;
    if (stb_count - c0 !== 1 || rx_busy !== 1'b0) begin
      bad++;
      $display("FAIL break_release got=n%0d busy=%b want=n1 busy=0", stb_count - c0, rx_busy);
    end
    send_frame(8'h55, 1'b1, 1'b0);
    idle_bits(2);
    total++;
    if (stb_count - c0 !== 2 || last_data !== 8'h55 || last_fe !== 1'b0) begin
      bad++;
      $display("FAIL break_after got=n%0d d%h fe%b want=n2 d55 fe0", stb_count - c0, last_data, last_fe);
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    c0 = stb_count;
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle_bits(2);
    total++;
    if (stb_count - c0 !== 2) begin
      bad++;
      $display("FAIL b2b_count got=%0d want=2", stb_count - c0);
    end
    total++;
    if (prev_data !== 8'h00 || last_data !== 8'hFF) begin
      bad++;
      $display("FAIL b2b_data got=%h,%h want=00,ff", prev_data, last_data);
    end
    total++;
    if (last_fe !== 1'b0 || last_pe !== 1'b0) begin
      bad++;
      $display("FAIL b2b_errs got=fe%b pe%b want=fe0 pe0", last_fe, last_pe);
    end
  endtask

  task automatic test_reset_midframe();
    int c0;
    c0 = stb_count;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    uart_rx = 1'b0;
    repeat (CPB / 2) @(posedge clk);
    #1;
    uart_rx = 1'b1;
    rst_n   = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_bits(15);
    total++;
    if (stb_count - c0 !== 0 || rx_busy !== 1'b0) begin
      bad++;
      $display("FAIL midrst_nostb got=n%0d busy=%b want=n0 busy=0", stb_count - c0, rx_busy);
    end
    total++;
    if (rx_data !== 8'h00) begin
      bad++;
      $display("FAIL midrst_data got=%h want=00", rx_data);
    end
    send_frame(8'h81, 1'b1, 1'b0);
    idle_bits(2);
    total++;
    if (stb_count - c0 !== 1 || last_data !== 8'h81) begin
      bad++;
      $display("FAIL midrst_after got=n%0d d%h want=n1 d81", stb_count - c0, last_data);
    end
  endtask

`ifdef RXUART_PARITY_EN
  task automatic test_parity();
    int c0;
    c0 = stb_count;
    send_frame(8'h07, 1'b1, 1'b1);
    idle_bits(2);
    total++;
    if (stb_count - c0 !== 1 || last_data !== 8'h07 || last_pe !== 1'b1 || last_fe !== 1'b0) begin
      bad++;
      $display("FAIL parity_err got=n%0d d%h pe%b fe%b want=n1 d07 pe1 fe0",
               stb_count - c0, last_data, last_pe, last_fe);
    end
  endtask
`endif

  initial begin
    rst_n   = 1'b0;
    uart_rx = 1'b1;
    #1;
    test_reset();
    test_single_frame();
    test_glitch();
    test_break();
    test_back_to_back();
    test_reset_midframe();
`ifdef RXUART_PARITY_EN
    test_parity();
`endif
    total++;
    if (stray !== 0) begin
      bad++;
      $display("FAIL err_without_stb got=%0d want=0", stray);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
